// File: rtl/mmio_pkg.sv
// Shared address map, register bit positions and address decode for the MMIO responder.
package mmio_pkg;

    localparam logic [11:0] ADDR_DISP   = 12'h400;
    localparam logic [11:0] ADDR_TIMER  = 12'h404;
    localparam logic [11:0] ADDR_CMP    = 12'h408;
    localparam logic [11:0] ADDR_STATUS = 12'h40C;
    localparam logic [11:0] ADDR_TXD    = 12'h410;
    localparam logic [11:0] ADDR_TXS    = 12'h414;

    localparam int unsigned STATUS_MATCH  = 0;
    localparam int unsigned STATUS_IRQ_EN = 1;
    localparam int unsigned TXS_FULL      = 4;
    localparam int unsigned TXS_EMPTY     = 5;
    localparam int unsigned TXS_OVERFLOW  = 6;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_DISP,
        SEL_TIMER,
        SEL_CMP,
        SEL_STATUS,
        SEL_TXD,
        SEL_TXS,
        SEL_NONE
    } regSel_t;

    // Word-address decode; the lower 1 KiB window is RAM, registers sit above it.
    function automatic regSel_t decodeAddr(input logic [9:0] wordAddr);
        logic [11:0] byteAddr;
        byteAddr = {wordAddr, 2'b00};
        if (wordAddr[9:8] == 2'b00) return SEL_RAM;
        case (byteAddr)
            ADDR_DISP:   return SEL_DISP;
            ADDR_TIMER:  return SEL_TIMER;
            ADDR_CMP:    return SEL_CMP;
            ADDR_STATUS: return SEL_STATUS;
            ADDR_TXD:    return SEL_TXD;
            ADDR_TXS:    return SEL_TXS;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_responder_tx_fifo.sv
// Byte-wide transmit FIFO with occupancy count; storage is not reset, only pointers.
module tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             pushOk;
    logic             popOk;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign popOk  = pop & ~empty;
    assign pushOk = push & (~full | popOk);

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            if (popOk)  rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: data RAM, display register, timer/compare with IRQ, and TX FIFO.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic [15:0] test_value,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [DEPTH];
    logic [9:0]        wordIdx;
    logic [RAM_AW-1:0] ramIdx;
    regSel_t           sel;
    logic              ramHit;
    logic              unusedAddrBits;

    logic [15:0] disp;
    logic [31:0] timer;
    logic [31:0] cmp;
    logic        match;
    logic        irqEn;
    logic        overflow;

    logic             wrDisp, wrCmp, wrStatus, wrTxd, wrTxs;
    logic             fifoPush, fifoPop, fifoFull, fifoEmpty, pushDrop;
    logic [CNT_W-1:0] fifoCount;
    logic [7:0]       fifoHead;

    assign wordIdx        = A[11:2];
    assign ramIdx         = wordIdx[RAM_AW-1:0];
    assign unusedAddrBits = ^{A[31:12], A[1:0]};
    assign sel            = decodeAddr(wordIdx);
    assign ramHit         = (sel == SEL_RAM) && ({22'd0, wordIdx} < 32'(DEPTH));

    assign wrDisp   = WE && (sel == SEL_DISP);
    assign wrCmp    = WE && (sel == SEL_CMP);
    assign wrStatus = WE && (sel == SEL_STATUS);
    assign wrTxd    = WE && (sel == SEL_TXD);
    assign wrTxs    = WE && (sel == SEL_TXS);

    assign fifoPop  = ~fifoEmpty & tx_ready;
    assign fifoPush = wrTxd & (~fifoFull | fifoPop);
    assign pushDrop = wrTxd & fifoFull & ~fifoPop;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) uTxFifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifoPush),
        .pushData (WD[7:0]),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (WE && ramHit) ram[ramIdx] <= WD;
    end

    // Sticky flags: a new set event outranks a write-1-clear landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp     <= '0;
            timer    <= '0;
            cmp      <= '0;
            match    <= 1'b0;
            irqEn    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            timer    <= timer + 32'd1;
            match    <= (timer == cmp) | (match & ~(wrStatus & WD[STATUS_MATCH]));
            overflow <= pushDrop | (overflow & ~(wrTxs & WD[TXS_OVERFLOW]));
            if (wrDisp)   disp  <= WD[15:0];
            if (wrCmp)    cmp   <= WD;
            if (wrStatus) irqEn <= WD[STATUS_IRQ_EN];
        end
    end

    always_comb begin
        RD = '0;
        case (sel)
            SEL_RAM:    if (ramHit) RD = ram[ramIdx];
            SEL_DISP:   RD = {16'd0, disp};
            SEL_TIMER:  RD = timer;
            SEL_CMP:    RD = cmp;
            SEL_STATUS: begin
                RD[STATUS_MATCH]  = match;
                RD[STATUS_IRQ_EN] = irqEn;
            end
            SEL_TXS: begin
                RD[3:0]          = 4'(fifoCount);
                RD[TXS_FULL]     = fifoFull;
                RD[TXS_EMPTY]    = fifoEmpty;
                RD[TXS_OVERFLOW] = overflow;
            end
            default:    RD = '0;
        endcase
    end

    assign test_value = disp;
    assign tx_data    = fifoHead;
    assign tx_valid   = ~fifoEmpty;
    assign irq        = match & irqEn;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder.
module tb_mmio_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic [15:0] test_value;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int unsigned checkCount = 0;
    int unsigned passCount  = 0;
    logic [31:0] cyc;

    mmio_responder #(
        .DEPTH      (256),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .A          (A),
        .WD         (WD),
        .WE         (WE),
        .RD         (RD),
        .test_value (test_value),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference timer: edges counted since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 32'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        A  = addr;
        WE = 1'b0;
        #1 check(tag, RD, exp);
    endtask

    initial begin
        reset_n  = 1'b0;
        A        = '0;
        WD       = '0;
        WE       = 1'b0;
        tx_ready = 1'b0;

        #12;
        check("rst_test_value", 32'(test_value), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        A = 32'h414;
        #1 check("rst_txs", RD, 32'h20);
        A = 32'h404;
        #1 check("rst_timer", RD, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Timer/compare/irq
        busWrite(32'h408, 32'd20);
        busWrite(32'h40C, 32'h3);
        readCheck("status_armed", 32'h40C, 32'h2);
        check("irq_before_match", 32'(irq), 32'h0);
        for (int i = 0; i < 100 && cyc < 32'd23; i++) @(negedge clk);
        check("match_wait", 32'(cyc >= 32'd23), 32'h1);
        readCheck("status_matched", 32'h40C, 32'h3);
        check("irq_matched", 32'(irq), 32'h1);
        busWrite(32'h40C, 32'h2 | 32'h1);
        busWrite(32'h40C, 32'h2);
        readCheck("status_w1c", 32'h40C, 32'h2);
        check("irq_cleared", 32'(irq), 32'h0);

        @(negedge clk);
        A = 32'h404;
        #1 check("timer_count", RD, cyc);
        busWrite(32'h404, 32'hFFFF0000);
        @(negedge clk);
        A = 32'h404;
        #1 check("timer_write_ignored", RD, cyc);

        // Compare hit and write-1-clear on the same edge: match must survive
        @(negedge clk);
        A  = 32'h408;
        WD = cyc + 32'd1;
        WE = 1'b1;
        @(negedge clk);
        A  = 32'h40C;
        WD = 32'h3;
        @(negedge clk);
        WE = 1'b0;
        #1 check("match_set_wins", RD, 32'h3);
        busWrite(32'h40C, 32'h1);
        readCheck("status_all_clear", 32'h40C, 32'h0);

        // RAM and decode
        busWrite(32'h010, 32'h1234ABCD);
        #1 check("ram_read_same_cycle", RD, 32'h1234ABCD);
        readCheck("ram_low_bits_ignored", 32'h012, 32'h1234ABCD);
        busWrite(32'h3FC, 32'hDEADBEEF);
        readCheck("ram_last_word", 32'h3FC, 32'hDEADBEEF);
        readCheck("unmapped_zero", 32'h800, 32'h0);
        readCheck("txd_write_only", 32'h410, 32'h0);

        // Display register
        busWrite(32'h400, 32'h0000BEEF);
        #1 check("disp_test_value", 32'(test_value), 32'h0000BEEF);
        busWrite(32'h400, 32'h12345678);
        readCheck("disp_low16", 32'h400, 32'h00005678);

        // FIFO fill, overflow, ordered drain
        for (int i = 0; i < 5; i++) busWrite(32'h410, 32'h41 + i);
        readCheck("txs_full_ovf", 32'h414, 32'h54);
        check("tx_valid_full", 32'(tx_valid), 32'h1);
        @(negedge clk);
        #1 check("tx_data_stable", 32'(tx_data), 32'h41);
        busWrite(32'h414, 32'h40);
        readCheck("txs_ovf_cleared", 32'h414, 32'h14);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("pop_order", 32'(tx_data), 32'h41 + i);
            @(negedge clk);
        end
        #1 check("drained_valid", 32'(tx_valid), 32'h0);
        A = 32'h414;
        #1 check("drained_txs", RD, 32'h20);
        tx_ready = 1'b0;

        // Push into a full FIFO while popping
        for (int i = 0; i < 4; i++) busWrite(32'h410, 32'h51 + i);
        @(negedge clk);
        A        = 32'h410;
        WD       = 32'h55;
        WE       = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        WE       = 1'b0;
        tx_ready = 1'b0;
        A        = 32'h414;
        #1 check("full_push_pop_txs", RD, 32'h14);
        check("full_push_pop_head", 32'(tx_data), 32'h52);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("pop_after_swap", 32'(tx_data), 32'h52 + i);
            @(negedge clk);
        end
        #1 check("swap_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Asynchronous reset with data queued
        busWrite(32'h020, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) busWrite(32'h410, 32'h61 + i);
        readCheck("txs_three", 32'h414, 32'h03);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_rst_valid", 32'(tx_valid), 32'h0);
        A = 32'h414;
        #1 check("async_rst_txs", RD, 32'h20);
        check("async_rst_disp", 32'(test_value), 32'h0);
        A = 32'h408;
        #1 check("async_rst_cmp", RD, 32'h0);
        A = 32'h020;
        #1 check("ram_retained", RD, 32'hCAFEF00D);
        @(negedge clk);
        reset_n = 1'b1;
        busWrite(32'h410, 32'h77);
        #1 check("post_rst_head", 32'(tx_data), 32'h77);
        readCheck("post_rst_txs", 32'h414, 32'h01);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
